// File: rtl/uart_tx_cfg_if.sv
`timescale 1ns/1ps
// uart_tx_cfg_if: valid/ready word handshake feeding the UART transmitter.
// The source drives in_valid/in_data (master); the transmitter answers with in_ready (slave).
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
// uart_tx_cfg: configurable UART transmitter (start, DATA_W data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, CLKS_PER_BIT clocks per bit).
// Build option UART_TX_CFG_FIFO_EN: a FIFO_DEPTH-entry input FIFO replaces the
// single holding register, and in_ready becomes !full.
module uart_tx_cfg #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave in_if,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic        PAR_INV   = (PARITY_MODE == 2);

  // Reject parameter sets the framer is not built for at elaboration time.
  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_cfg: illegal parameter set");
  end

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] sh_q;
  logic              par_q, tx_q, busy_q, done_q;

  logic              push, load, stop_last, head_v;
  logic [DATA_W-1:0] head_d, word;

  // Last clock of the final stop period: frame ends on the next edge.
  assign stop_last = (state_q == STOP) && (cnt_q == 16'd0) && (bit_q == LAST_STOP);
  assign push      = in_if.in_valid && in_if.in_ready;
  // From IDLE only a buffered word starts a frame (one cycle accept-to-start);
  // at the end of a frame a word arriving on that very edge is passed straight in.
  assign load      = ((state_q == IDLE) && head_v) || (stop_last && (head_v || push));
  assign word      = head_v ? head_d : in_if.in_data;

`ifdef UART_TX_CFG_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              empty, full, wr_en, rd_en;

  assign empty          = (wr_q == rd_q);
  assign full           = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign in_if.in_ready = !rst && !full;
  assign head_v         = !empty;
  assign head_d         = mem_q[rd_q[AW-1:0]];
  // Push and pop while empty bypasses the storage, so the count stays 0.
  assign wr_en          = push && !(load && empty);
  assign rd_en          = load && !empty;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= in_if.in_data;
  end
`else
  logic              hold_v_q;
  logic [DATA_W-1:0] hold_q;

  // Ready only when the holder is empty and the framer can take a word soon.
  assign in_if.in_ready = !rst && !hold_v_q && ((state_q == IDLE) || stop_last);
  assign head_v         = hold_v_q;
  assign head_d         = hold_q;

  // Single holding register between the handshake and the framer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else if (load) begin
      hold_v_q <= 1'b0;
    end else if (push) begin
      hold_v_q <= 1'b1;
      hold_q   <= in_if.in_data;
    end
  end
`endif

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= stop_last;
      if (load) begin
        state_q <= START;
        cnt_q   <= CNT_MAX;
        bit_q   <= '0;
        sh_q    <= word;
        par_q   <= (^word) ^ PAR_INV;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          START: begin
            if (cnt_q == 16'd0) begin
              state_q <= DATA;
              cnt_q   <= CNT_MAX;
              bit_q   <= '0;
              tx_q    <= sh_q[0];
            end else cnt_q <= cnt_q - 16'd1;
          end
          DATA: begin
            if (cnt_q == 16'd0) begin
              cnt_q <= CNT_MAX;
              if (bit_q == LAST_DATA) begin
                bit_q <= '0;
                if (PARITY_MODE != 0) begin
                  state_q <= PARITY;
                  tx_q    <= par_q;
                end else begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bit_q <= bit_q + 4'd1;
                sh_q  <= sh_q >> 1;
                tx_q  <= sh_q[1];
              end
            end else cnt_q <= cnt_q - 16'd1;
          end
          PARITY: begin
            if (cnt_q == 16'd0) begin
              state_q <= STOP;
              cnt_q   <= CNT_MAX;
              bit_q   <= '0;
              tx_q    <= 1'b1;
            end else cnt_q <= cnt_q - 16'd1;
          end
          STOP: begin
            if (cnt_q == 16'd0) begin
              if (bit_q == LAST_STOP) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + 4'd1;
                cnt_q <= CNT_MAX;
              end
              tx_q <= 1'b1;
            end else cnt_q <= cnt_q - 16'd1;
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
// tb_uart_tx_cfg: directed bench over four configurations sharing clk/rst:
// u0 8N1, u1 8E1, u2 8O1, u3 7N2, all with 4 clocks per bit.
// Build option UART_TX_CFG_FIFO_EN adds the FIFO burst sequence on u0.
module tb_uart_tx_cfg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] v   = '0;
  logic [7:0] d [4];
  wire  [3:0] tx_w, busy_w, done_w, rdy_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_W(8)) if0 ();
  uart_tx_cfg_if #(.DATA_W(8)) if1 ();
  uart_tx_cfg_if #(.DATA_W(8)) if2 ();
  uart_tx_cfg_if #(.DATA_W(7)) if3 ();

  assign if0.in_valid = v[0];  assign if0.in_data = d[0];       assign rdy_w[0] = if0.in_ready;
  assign if1.in_valid = v[1];  assign if1.in_data = d[1];       assign rdy_w[1] = if1.in_ready;
  assign if2.in_valid = v[2];  assign if2.in_data = d[2];       assign rdy_w[2] = if2.in_ready;
  assign if3.in_valid = v[3];  assign if3.in_data = d[3][6:0];  assign rdy_w[3] = if3.in_ready;

  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_if(if0), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_if(if1), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_if(if2), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_cfg #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .in_if(if3), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line bits (index 0 = start bit) stretched to 4 clocks each.
  function automatic logic [63:0] expand(input logic [15:0] b, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) r[i*4+j] = b[i];
    return r;
  endfunction

  // Wait for a start bit, then sample tx for len clocks; report the first
  // clock (>=1) where done is seen and how many clocks were spent waiting.
  task automatic capture(input int idx, input int len, output logic [63:0] samp,
                         output int done_at, output int gap);
    samp = '0; done_at = -1; gap = 0;
    while (tx_w[idx] !== 1'b0 && gap < 300) begin
      @(negedge clk); gap++;
    end
    if (gap >= 300) begin
      done_at = -2; gap = -1;
      return;
    end
    for (int k = 0; k <= len; k++) begin
      if (k < len) samp[k] = tx_w[idx];
      if (k >= 1 && done_w[idx] === 1'b1 && done_at < 0) done_at = k;
      if (k < len) @(negedge clk);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] data);
    int t;
    @(negedge clk);
    v[idx] = 1'b1; d[idx] = data; t = 0;
    while (rdy_w[idx] !== 1'b1 && t < 300) begin
      @(negedge clk); t++;
    end
    check("send_ready_timeout", 64'(t < 300), 64'd1);
    @(posedge clk);
    #1 v[idx] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s;
    int          da, g, dcnt, lcnt;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",    64'(tx_w),   64'hF);
    check("rst_busy",  64'(busy_w), 64'h0);
    check("rst_done",  64'(done_w), 64'h0);
    check("rst_ready", 64'(rdy_w),  64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(rdy_w), 64'hF);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1 x4 clocks, done 40 clocks after start
    send(0, 8'hA5);
    capture(0, 40, s, da, g);
    check("8n1_a5_line", s, expand(16'b11010_01010, 10));
    check("8n1_a5_done", 64'(da), 64'd40);
    @(negedge clk);
    check("8n1_idle_busy", 64'(busy_w[0]), 64'd0);

    // 8E1 0xA5: parity 0, 44 clocks
    send(1, 8'hA5);
    capture(1, 44, s, da, g);
    check("8e1_a5_line", s, expand(16'b101010_01010, 11));
    check("8e1_a5_done", 64'(da), 64'd44);

    // 8O1 0xA5: parity 1, 44 clocks
    send(2, 8'hA5);
    capture(2, 44, s, da, g);
    check("8o1_a5_line", s, expand(16'b111010_01010, 11));
    check("8o1_a5_done", 64'(da), 64'd44);

    // 7N2 0x7F: 8 high clocks of stop after data, 40 clocks
    send(3, 8'h7F);
    capture(3, 40, s, da, g);
    check("7n2_7f_line", s, expand(16'b11_1111111_0, 10));
    check("7n2_7f_done", 64'(da), 64'd40);

    // in_valid held with junk data while not ready; back-to-back 0x11, 0x22
    fork
      begin
        logic [7:0] words [2];
        int t;
        words[0] = 8'h11; words[1] = 8'h22;
        for (int w = 0; w < 2; w++) begin
          t = 0;
          while (t < 300) begin
            @(negedge clk);
            v[0] = 1'b1;
            if (rdy_w[0] === 1'b1) begin
              d[0] = words[w];
              @(posedge clk);
              break;
            end
            d[0] = 8'hF0 ^ 8'(t);
            t++;
          end
          check("b2b_drv_timeout", 64'(t < 300), 64'd1);
        end
        #1 v[0] = 1'b0;
      end
      begin
        capture(0, 40, s, da, g);
        check("b2b_f1_line", s, expand(16'b10001_00010, 10));
        check("b2b_f1_done", 64'(da), 64'd40);
        capture(0, 40, s, da, g);
        check("b2b_gap",     64'(g), 64'd0);
        check("b2b_f2_line", s, expand(16'b10010_00100, 10));
        check("b2b_f2_done", 64'(da), 64'd40);
      end
    join
    @(negedge clk);

    // Reset during data bit 3 of 0x3C
    send(0, 8'h3C);
    g = 0;
    while (tx_w[0] !== 1'b0 && g < 300) begin
      @(negedge clk); g++;
    end
    check("rstmid_start_timeout", 64'(g < 300), 64'd1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_tx",    64'(tx_w[0]),   64'd1);
    check("rstmid_busy",  64'(busy_w[0]), 64'd0);
    check("rstmid_done",  64'(done_w[0]), 64'd0);
    check("rstmid_ready", 64'(rdy_w[0]),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0; lcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) dcnt++;
      if (tx_w[0] !== 1'b1) lcnt++;
    end
    check("rstmid_no_done", 64'(dcnt), 64'd0);
    check("rstmid_line_idle", 64'(lcnt), 64'd0);
    send(0, 8'h55);
    capture(0, 40, s, da, g);
    check("after_rst_55_line", s, expand(16'b10101_01010, 10));
    check("after_rst_55_done", 64'(da), 64'd40);
    @(negedge clk);

`ifdef UART_TX_CFG_FIFO_EN
    // Burst of 5 words: one in flight plus 4 buffered, then in_ready drops
    fork
      begin
        for (int w = 1; w <= 5; w++) begin
          @(negedge clk);
          check("fifo_ready_during_burst", 64'(rdy_w[0]), 64'd1);
          v[0] = 1'b1; d[0] = 8'(w);
        end
        @(negedge clk);
        check("fifo_full_ready", 64'(rdy_w[0]), 64'd0);
        v[0] = 1'b0;
      end
      begin
        for (int f = 1; f <= 5; f++) begin
          capture(0, 40, s, da, g);
          check("fifo_frame_line", s, expand({6'd0, 1'b1, 8'(f), 1'b0}, 10));
          check("fifo_frame_done", 64'(da), 64'd40);
          if (f > 1) check("fifo_frame_gap", 64'(g), 64'd0);
        end
      end
    join
    @(negedge clk);
    check("fifo_drained_busy", 64'(busy_w[0]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
